rs_issue_sched: RTL and testbench

Age-ordered issue scheduler for the reservation station. It tracks which RS entries are occupied, their relative age and their functional-unit class. Each cycle it grants up to three issue ports, always picking the oldest ready compatible entry. It also sequences the non-pipelined multiplier with a busy counter so that MUL ops are never issued while the unit is occupied. It sits between the RS entry array (which supplies operand-ready bits and receives grant indices) and the execute ports.

---
 rtl/rs_issue_sched.sv | 109 ++++++++++
 tb/tb_rs_issue_sched.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_issue_sched.sv
// Age-ordered issue scheduler: up to three grants per cycle (ALU/BRC, ALU/MEM, MUL).
// Picks the oldest ready compatible RS entry per port and paces the non-pipelined multiplier.

module rs_age_pick #(
    parameter int SIZE = 16,
    parameter int IW   = $clog2(SIZE)
) (
    input  logic [SIZE-1:0]           cand,
    input  logic [SIZE-1:0][SIZE-1:0] age,
    output logic [SIZE-1:0]           onehot,
    output logic [IW-1:0]             idx
);
    // An entry wins when no other candidate is older than it.
    always_comb begin
        onehot = '0;
        idx    = '0;
        for (int i = 0; i < SIZE; i++) begin
            onehot[i] = cand[i];
            for (int j = 0; j < SIZE; j++)
                if (j != i && cand[j] && age[j][i]) onehot[i] = 1'b0;
        end
        for (int i = 0; i < SIZE; i++)
            if (onehot[i]) idx = idx | IW'(i);
    end
endmodule

module rs_issue_sched #(
    parameter  int SIZE    = 16,
    parameter  int MUL_LAT = 4,
    localparam int IW      = $clog2(SIZE)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 alloc_valid,
    input  logic [IW-1:0]        alloc_idx,
    input  logic [1:0]           alloc_cls,
    input  logic [SIZE-1:0]      ready,
    input  logic [SIZE-1:0]      kill,
    input  logic [2:0]           port_avail,
    output logic [2:0]           grant_valid,
    output logic [2:0][IW-1:0]   grant_idx,
    output logic [SIZE-1:0]      occupied,
    output logic                 mul_busy
);
    localparam int MW = $clog2(MUL_LAT) + 1;

    logic [SIZE-1:0]           v;
    logic [SIZE-1:0][1:0]      cls;
    logic [SIZE-1:0][SIZE-1:0] age;
    logic [MW-1:0]             mcnt;

    logic [SIZE-1:0] elig, cand0, cand1, cand2;
    logic [SIZE-1:0] oh0, oh1, oh2, gnt_any;
    logic [IW-1:0]   idx0, idx1, idx2;

    assign elig = v & ready & ~kill;

    // Port 1 only excludes what port 0 actually granted, so an unavailable
    // port 0 leaves its would-be pick open to port 1.
    always_comb begin
        cand0 = '0;
        cand2 = '0;
        for (int i = 0; i < SIZE; i++) begin
            cand0[i] = elig[i] && port_avail[0] && (cls[i] == 2'd0 || cls[i] == 2'd1);
            cand2[i] = elig[i] && port_avail[2] && (mcnt == '0) && (cls[i] == 2'd3);
        end
    end

    always_comb begin
        cand1 = '0;
        for (int i = 0; i < SIZE; i++)
            cand1[i] = elig[i] && !oh0[i] && port_avail[1] && (cls[i] == 2'd0 || cls[i] == 2'd2);
    end

    rs_age_pick #(.SIZE(SIZE), .IW(IW)) pick0 (.cand(cand0), .age(age), .onehot(oh0), .idx(idx0));
    rs_age_pick #(.SIZE(SIZE), .IW(IW)) pick1 (.cand(cand1), .age(age), .onehot(oh1), .idx(idx1));
    rs_age_pick #(.SIZE(SIZE), .IW(IW)) pick2 (.cand(cand2), .age(age), .onehot(oh2), .idx(idx2));

    assign gnt_any      = oh0 | oh1 | oh2;
    assign grant_valid  = {|oh2, |oh1, |oh0};
    assign grant_idx[0] = idx0;
    assign grant_idx[1] = idx1;
    assign grant_idx[2] = idx2;
    assign occupied     = v;
    assign mul_busy     = (mcnt != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            v    <= '0;
            cls  <= '0;
            age  <= '0;
            mcnt <= '0;
        end else begin
            v <= v & ~gnt_any & ~kill;
            if (grant_valid[2])
                mcnt <= MW'(MUL_LAT - 1);
            else if (mcnt != '0)
                mcnt <= mcnt - 1'b1;
            // Allocation overrides a same-cycle free of the previous occupant.
            if (alloc_valid) begin
                v[alloc_idx]   <= 1'b1;
                cls[alloc_idx] <= alloc_cls;
                age[alloc_idx] <= '0;
                for (int j = 0; j < SIZE; j++)
                    if (IW'(j) != alloc_idx) age[j][alloc_idx] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rs_issue_sched.sv
// Randomized + directed bench for rs_issue_sched against an ordered-list reference model.
module tb_rs_issue_sched;
    localparam int SIZE = 16;
    localparam int IW = 4;
    localparam int MUL_LAT = 4;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 alloc_valid;
    logic [IW-1:0]        alloc_idx;
    logic [1:0]           alloc_cls;
    logic [SIZE-1:0]      ready;
    logic [SIZE-1:0]      kill;
    logic [2:0]           port_avail;
    logic [2:0]           grant_valid;
    logic [2:0][IW-1:0]   grant_idx;
    logic [SIZE-1:0]      occupied;
    logic                 mul_busy;

    rs_issue_sched #(.SIZE(SIZE), .MUL_LAT(MUL_LAT)) dut (
        .clock(clock), .reset(reset), .alloc_valid(alloc_valid), .alloc_idx(alloc_idx),
        .alloc_cls(alloc_cls), .ready(ready), .kill(kill), .port_avail(port_avail),
        .grant_valid(grant_valid), .grant_idx(grant_idx), .occupied(occupied), .mul_busy(mul_busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]         gv;
        logic [2:0][IW-1:0] gi;
        logic [SIZE-1:0]    occ;
        logic               busy;
    } exp_t;

    exp_t exp_q[$];
    exp_t me;
    int   checks = 0;
    int   failures = 0;

    // Reference state: valid entries listed oldest first, class per slot, multiplier cooldown.
    int order[$];
    int mcls[SIZE];
    int mc = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
        end
    endtask

    function automatic bit in_order(input int idx);
        foreach (order[k]) if (order[k] == idx) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int pick(input logic [SIZE-1:0] rdy, input logic [SIZE-1:0] kl,
                                input int ca, input int cb, input int excl);
        foreach (order[k]) begin
            int e = order[k];
            if (rdy[e] && !kl[e] && (mcls[e] == ca || mcls[e] == cb) && e != excl) return e;
        end
        return -1;
    endfunction

    task automatic step(input logic av, input int ai, input int ac, input logic [SIZE-1:0] rdy,
                        input logic [SIZE-1:0] kl, input logic [2:0] pa, input logic rst);
        exp_t e;
        int   g[3];
        @(posedge clock); #1;
        reset = rst; alloc_valid = av; alloc_idx = IW'(ai); alloc_cls = 2'(ac);
        ready = rdy; kill = kl; port_avail = pa;
        g[0] = pa[0] ? pick(rdy, kl, 0, 1, -1) : -1;
        g[1] = pa[1] ? pick(rdy, kl, 0, 2, g[0]) : -1;
        g[2] = (pa[2] && mc == 0) ? pick(rdy, kl, 3, 3, -1) : -1;
        e.gv = '0; e.gi = '0; e.occ = '0;
        for (int p = 0; p < 3; p++)
            if (g[p] >= 0) begin e.gv[p] = 1'b1; e.gi[p] = IW'(g[p]); end
        foreach (order[k]) e.occ[order[k]] = 1'b1;
        e.busy = (mc != 0);
        exp_q.push_back(e);
        if (rst) begin
            order.delete();
            mc = 0;
        end else begin
            for (int k = order.size() - 1; k >= 0; k--)
                if (kl[order[k]] || order[k] == g[0] || order[k] == g[1] || order[k] == g[2])
                    order.delete(k);
            if (av) begin
                for (int k = order.size() - 1; k >= 0; k--)
                    if (order[k] == ai) order.delete(k);
                order.push_back(ai);
                mcls[ai] = ac;
            end
            if (g[2] >= 0) mc = MUL_LAT - 1;
            else if (mc > 0) mc--;
        end
        @(negedge clock); #1;
    endtask

    task automatic idle();
        step(1'b0, 0, 0, '0, '0, 3'b000, 1'b0);
    endtask

    task automatic alloc(input int ai, input int ac);
        step(1'b1, ai, ac, '0, '0, 3'b000, 1'b0);
    endtask

    // Scoreboard monitor plus alloc-protocol watch.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            cmp("grant_valid", 32'(grant_valid), 32'(me.gv));
            cmp("grant_idx", 32'(grant_idx), 32'(me.gi));
            cmp("occupied", 32'(occupied), 32'(me.occ));
            cmp("mul_busy", 32'(mul_busy), 32'(me.busy));
        end
        if (reset === 1'b0 && alloc_valid === 1'b1 && occupied[alloc_idx] && !kill[alloc_idx] &&
            !((grant_valid[0] && grant_idx[0] == alloc_idx) ||
              (grant_valid[1] && grant_idx[1] == alloc_idx) ||
              (grant_valid[2] && grant_idx[2] == alloc_idx))) begin
            failures++;
            $display("FAIL alloc_protocol idx=%0d occupied=%0h", alloc_idx, occupied);
        end
    end

    initial begin
        logic [SIZE-1:0] r;
        reset = 1'b1; alloc_valid = 1'b0; alloc_idx = '0; alloc_cls = '0;
        ready = '0; kill = '0; port_avail = '0;
        repeat (2) @(posedge clock);

        // reset state
        step(1'b0, 0, 0, '1, '0, 3'b111, 1'b0);
        cmp("reset_occ", 32'(occupied), 0);
        cmp("reset_gv", 32'(grant_valid), 0);
        cmp("reset_gi", 32'(grant_idx), 0);

        // age order
        alloc(5, 0); alloc(2, 0); alloc(9, 0);
        r = '0; r[5] = 1'b1; r[2] = 1'b1; r[9] = 1'b1;
        step(1'b0, 0, 0, r, '0, 3'b011, 1'b0);
        cmp("age_p0", 32'(grant_idx[0]), 5);
        cmp("age_p1", 32'(grant_idx[1]), 2);
        step(1'b0, 0, 0, r, '0, 3'b011, 1'b0);
        cmp("age_p0_next", 32'(grant_idx[0]), 9);
        cmp("age_occ", 32'(occupied), 32'h200);
        idle();
        cmp("age_occ_clear", 32'(occupied), 0);

        // class steering
        alloc(0, 1); alloc(1, 2);
        step(1'b0, 0, 0, 16'h3, '0, 3'b101, 1'b0);
        cmp("cls_gv_noport1", 32'(grant_valid), 3'b001);
        cmp("cls_brc_p0", 32'(grant_idx[0]), 0);
        step(1'b0, 0, 0, 16'h3, '0, 3'b011, 1'b0);
        cmp("cls_gv_mem", 32'(grant_valid), 3'b010);
        cmp("cls_mem_p1", 32'(grant_idx[1]), 1);

        // multiplier pacing
        alloc(3, 3); alloc(4, 3);
        r = '0; r[3] = 1'b1; r[4] = 1'b1;
        step(1'b0, 0, 0, r, '0, 3'b111, 1'b0);
        cmp("mul_first", 32'(grant_idx[2]), 3);
        for (int k = 1; k <= 3; k++) begin
            step(1'b0, 0, 0, r, '0, 3'b111, 1'b0);
            cmp("mul_busy_hold", 32'(mul_busy), 1);
            cmp("mul_no_grant", 32'(grant_valid[2]), 0);
        end
        step(1'b0, 0, 0, r, '0, 3'b111, 1'b0);
        cmp("mul_second_v", 32'(grant_valid[2]), 1);
        cmp("mul_second", 32'(grant_idx[2]), 4);
        repeat (4) idle();

        // kill, then kill with same-cycle realloc
        alloc(7, 0);
        r = '0; r[7] = 1'b1;
        step(1'b0, 0, 0, r, r, 3'b111, 1'b0);
        cmp("kill_no_grant", 32'(grant_valid), 0);
        idle();
        cmp("kill_occ", 32'(occupied[7]), 0);
        alloc(8, 0); alloc(7, 0);
        step(1'b1, 7, 0, '0, r, 3'b000, 1'b0);
        r[8] = 1'b1;
        step(1'b0, 0, 0, r, '0, 3'b001, 1'b0);
        cmp("kill_realloc_occ", 32'(occupied[7]), 1);
        cmp("kill_realloc_young", 32'(grant_idx[0]), 8);
        step(1'b0, 0, 0, r, '0, 3'b001, 1'b0);
        idle();

        // full and wrap
        for (int k = 15; k >= 0; k--) alloc(k, 0);
        for (int c = 0; c <= 8; c++) begin
            step(c == 1, 15, 0, '1, '0, 3'b011, 1'b0);
            if (c == 0) cmp("full_occ", 32'(occupied), 32'hffff);
            if (c < 8) begin
                cmp("full_p0", 32'(grant_idx[0]), 32'(15 - 2 * c));
                cmp("full_p1", 32'(grant_idx[1]), 32'(14 - 2 * c));
            end else begin
                cmp("wrap_gv", 32'(grant_valid), 3'b001);
                cmp("wrap_young", 32'(grant_idx[0]), 15);
            end
        end
        idle();

        // reset mid-op
        alloc(3, 3); alloc(1, 0); alloc(2, 0);
        r = '0; r[3] = 1'b1;
        step(1'b0, 0, 0, r, '0, 3'b100, 1'b0);
        cmp("rst_mul_grant", 32'(grant_idx[2]), 3);
        idle();
        step(1'b0, 0, 0, '0, '0, 3'b000, 1'b1);
        step(1'b1, 6, 3, '0, '0, 3'b111, 1'b0);
        cmp("rst_occ", 32'(occupied), 0);
        cmp("rst_busy", 32'(mul_busy), 0);
        cmp("rst_gv", 32'(grant_valid), 0);
        r = '0; r[6] = 1'b1;
        step(1'b0, 0, 0, r, '0, 3'b111, 1'b0);
        cmp("rst_fresh_mul", 32'(grant_valid[2]), 1);
        cmp("rst_fresh_idx", 32'(grant_idx[2]), 6);

        // randomized traffic
        repeat (500) begin
            logic            av;
            int              ai;
            logic [SIZE-1:0] kl;
            av = 1'($urandom_range(0, 1));
            ai = 0;
            if (order.size() >= SIZE) av = 1'b0;
            if (av) begin
                ai = $urandom_range(0, SIZE - 1);
                while (in_order(ai)) ai = $urandom_range(0, SIZE - 1);
            end
            kl = '0;
            if ($urandom_range(0, 7) == 0) kl[$urandom_range(0, SIZE - 1)] = 1'b1;
            step(av, ai, $urandom_range(0, 3), SIZE'($urandom), kl, 3'($urandom),
                 $urandom_range(0, 99) == 0);
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
